i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Round-robin arbiter and sequencer that shares one I2C master (transmitter) between NREQ requesters. Each requester posts a complete transaction (direction, 7-bit target address, 16-bit write data). The block picks one requester, issues a single START_STB to the master and waits for the master's completion pulse or a timeout. It then returns read data and status to the winning requester. It sits between the CPU-side client blocks and the I2C master, and is the only driver of the master's command inputs.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 1023: maximum cycles in WAIT before a transaction is aborted with error, ≥ 2.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request level; slot i is bit i.
- req_rnw  in  NREQ  per-requester direction: 1 = read, 0 = write.
- req_addr  in  7*NREQ  per-requester target address; slot i is bits [7i+6:7i].
- req_wdata  in  16*NREQ  per-requester write data; slot i is bits [16i+15:16i].
- gnt  out  NREQ  one-hot grant, active from ISSUE through RESP.
- done  out  NREQ  one-cycle completion pulse to the granted slot.
- rd_data  out  16  read data, valid only while any done bit is high.
- err  out  1  error flag, valid only while any done bit is high.
- busy  out  1  high whenever state ≠ IDLE.
- m_start_stb  out  1  one-cycle start strobe to the I2C master.
- m_rnw  out  1  latched direction to the master.
- m_addr  out  7  latched address to the master.
- m_wdata  out  16  latched write data to the master.
- m_rd_data  in  16  read data from the master, sampled on m_done.
- m_done  in  1  one-cycle transaction-complete pulse from the master.
- m_nack  in  1  master NACK status, sampled with m_done.

## Operation
- State machine: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE, any req high:
  - Winner is the first set bit scanning upward from ptr, wrapping modulo NREQ.
  - Latch the winner's rnw, addr and wdata into m_rnw, m_addr and m_wdata.
  - Latch the winner's index; go to ISSUE.
  - With no req high, stay in IDLE.
- ISSUE: m_start_stb = 1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT:
  - On m_done: capture m_rd_data; err_r = m_nack; go to RESP.
  - Otherwise the timer increments each cycle.
  - When timer == TIMEOUT-1 with no m_done: rd_data_r = 0; err_r = 1; go to RESP.
- RESP:
  - done[idx] = 1 for this cycle; rd_data and err are driven from the captured registers.
  - ptr = (idx+1) mod NREQ; go to IDLE.
- m_rnw, m_addr and m_wdata hold their latched values from ISSUE until the next latch; requester inputs may change after grant.
- req is level-sensitive. A requester that keeps req high after its done pulse is treated as a new request in the next IDLE cycle and competes under round-robin.
- A requester dropping req while granted has no effect; the transaction completes and done still pulses.
- Write transactions return rd_data = m_rd_data as supplied by the master; requesters ignore it.
- Timer width is clog2(TIMEOUT+1) bits and it never wraps.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, done 0, rd_data 0, err 0, busy 0, m_start_stb 0, m_rnw 0, m_addr 0, m_wdata 0, timer 0.
- req sampled high in IDLE at cycle 0 → m_start_stb and gnt at cycle 1 → WAIT from cycle 2.
- m_done at cycle k → done and rd_data at cycle k+1 → IDLE at k+2 → next m_start_stb earliest at k+3.
- Timeout: with no m_done, done/err is asserted TIMEOUT cycles after the first WAIT cycle.
- m_done in the same cycle the timeout would fire: m_done wins, err = m_nack.
- m_done outside WAIT (IDLE, ISSUE, RESP) is ignored and no state changes.
- Only one transaction is outstanding at a time; m_start_stb never asserts while busy, except in ISSUE.
- rst low in any state returns every register to its reset value on that edge. The in-flight requester receives no done pulse; the master is reset by the same rst.

## Test plan
- Single write: req[1]=1, rnw=0, addr=0x48, wdata=0xBEEF; master returns m_done 10 cycles after start → m_addr=0x48, m_wdata=0xBEEF, m_start_stb one cycle, done[1] at WAIT-entry+10, err=0.
- Read with NACK: req[0], rnw=1, addr=0x50; master returns m_done with m_rd_data=0x1234 and m_nack=1 → done[0], rd_data=0x1234, err=1.
- Round-robin: req=4'b1111 held high, master completes each in 5 cycles → grant order 0,1,2,3,0; no slot granted twice before the others.
- Timeout: TIMEOUT=8, master never pulses m_done → done[2] and err=1, rd_data=0, exactly 8 cycles after WAIT entry; busy drops the next cycle.
- Simultaneous and stray events: m_done on the timeout cycle → err=m_nack. m_done pulsed in IDLE → no done, state stays IDLE.
- Reset mid-WAIT: rst=0 for one cycle during WAIT → all outputs at reset values next cycle, no done pulse, ptr=0; a new req[3] is then granted normally.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C master between NREQ requesters.
// It issues one START_STB per transaction and returns the result or a timeout error.
module i2c_master_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rnw,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [16*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          rd_data,
  output logic                 err,
  output logic                 busy,
  output logic                 m_start_stb,
  output logic                 m_rnw,
  output logic [6:0]           m_addr,
  output logic [15:0]          m_wdata,
  input  logic [15:0]          m_rd_data,
  input  logic                 m_done,
  input  logic                 m_nack
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_idx, w_win;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_rd_data;
  logic            r_err, r_rnw, w_found, w_tmo;
  logic [6:0]      r_addr;
  logic [15:0]     r_wdata;
  logic [NREQ-1:0] w_onehot;

  assign w_tmo = (r_timer == TW'(TIMEOUT - 1));

  // Scan upward from the pointer, wrapping, and take the first pending request.
  always_comb begin
    int unsigned c;
    c       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = 32'(r_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!w_found && req[c]) begin
        w_found = 1'b1;
        w_win   = IW'(c);
      end
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  always_comb begin
    w_next      = r_state;
    gnt         = '0;
    done        = '0;
    rd_data     = '0;
    err         = 1'b0;
    busy        = (r_state != S_IDLE);
    m_start_stb = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: begin
        gnt         = w_onehot;
        m_start_stb = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        gnt = w_onehot;
        if (m_done || w_tmo) w_next = S_RESP;
      end
      S_RESP: begin
        gnt     = w_onehot;
        done    = w_onehot;
        rd_data = r_rd_data;
        err     = r_err;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_rnw     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_idx   <= w_win;
          r_rnw   <= req_rnw[w_win];
          r_addr  <= req_addr[w_win*7 +: 7];
          r_wdata <= req_wdata[w_win*16 +: 16];
        end
        S_ISSUE: r_timer <= '0;
        // m_done takes priority over a timeout landing on the same cycle.
        S_WAIT: begin
          if (m_done) begin
            r_rd_data <= m_rd_data;
            r_err     <= m_nack;
          end else if (w_tmo) begin
            r_rd_data <= '0;
            r_err     <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  assign m_rnw   = r_rnw;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed self-checking bench for i2c_master_arbiter: table-driven transactions
// plus hand sequences for round-robin, timeout, stray m_done and reset mid-WAIT.
module tb_i2c_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, t_req;
  logic [3:0]  req_rnw;
  logic [27:0] req_addr;
  logic [63:0] req_wdata;
  logic [15:0] m_rd_data;
  logic        m_done, m_nack;

  logic [3:0]  gnt, done;
  logic [15:0] rd_data, m_wdata;
  logic        err, busy, m_start_stb, m_rnw;
  logic [6:0]  m_addr;

  logic [3:0]  t_gnt, t_done;
  logic [15:0] t_rd_data, t_m_wdata;
  logic        t_err, t_busy, t_m_start_stb, t_m_rnw;
  logic [6:0]  t_m_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NREQ(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rd_data(rd_data), .err(err),
    .busy(busy), .m_start_stb(m_start_stb), .m_rnw(m_rnw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rd_data(m_rd_data), .m_done(m_done), .m_nack(m_nack)
  );

  i2c_master_arbiter #(.NREQ(4), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .req(t_req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(t_gnt), .done(t_done), .rd_data(t_rd_data), .err(t_err),
    .busy(t_busy), .m_start_stb(t_m_start_stb), .m_rnw(t_m_rnw), .m_addr(t_m_addr),
    .m_wdata(t_m_wdata), .m_rd_data(m_rd_data), .m_done(m_done), .m_nack(m_nack)
  );

  typedef struct {
    int          slot;
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] mrd;
    logic        nack;
    logic [3:0]  exp_gnt;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic rnw, input logic [6:0] a, input logic [15:0] d);
    req_rnw[i]          = rnw;
    req_addr[i*7 +: 7]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic decoy(input logic rnw);
    for (int i = 0; i < 4; i++) set_slot(i, rnw, 7'h2A, 16'hDEAD);
  endtask

  task automatic wait_start();
    int cyc;
    cyc = 0;
    while (m_start_stb !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("start_seen", m_start_stb, 1);
  endtask

  // Entered in the ISSUE cycle; m_done is returned lat cycles after the strobe.
  task automatic serve(input string nm, input logic [3:0] exp_gnt, input int lat,
                       input logic [15:0] mrd, input logic nack, input logic [15:0] exp_rd,
                       input logic exp_err, input logic [6:0] exp_addr, input logic [15:0] exp_wd);
    bit early;
    early = 0;
    chk({nm, "_gnt"}, gnt, exp_gnt);
    tick();
    chk({nm, "_stb_once"}, m_start_stb, 0);
    chk({nm, "_gnt_wait"}, gnt, exp_gnt);
    for (int i = 1; i < lat; i++) begin
      tick();
      if (done !== 4'b0000) early = 1;
    end
    chk({nm, "_no_early_done"}, early, 0);
    m_done = 1'b1; m_rd_data = mrd; m_nack = nack;
    tick();
    m_done = 1'b0; m_rd_data = 16'h0BAD; m_nack = 1'b0;
    chk({nm, "_done"}, done, exp_gnt);
    chk({nm, "_rd"}, rd_data, exp_rd);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_addr_held"}, m_addr, exp_addr);
    chk({nm, "_wd_held"}, m_wdata, exp_wd);
    tick();
    chk({nm, "_done_clr"}, done, 0);
    chk({nm, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_gnt [5];
    logic [6:0] rr_addr [5];
    bit         quiet;

    tbl[0] = '{1, 1'b0, 7'h48, 16'hBEEF, 10, 16'h5A5A, 1'b0, 4'b0010, 16'h5A5A, 1'b0};
    tbl[1] = '{0, 1'b1, 7'h50, 16'h0000, 4,  16'h1234, 1'b1, 4'b0001, 16'h1234, 1'b1};
    tbl[2] = '{3, 1'b0, 7'h7F, 16'h0001, 1,  16'hFFFF, 1'b0, 4'b1000, 16'hFFFF, 1'b0};
    tbl[3] = '{2, 1'b1, 7'h00, 16'h8000, 3,  16'hA5C3, 1'b0, 4'b0100, 16'hA5C3, 1'b0};
    rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_addr = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h10};

    rst = 1'b0; req = '0; t_req = '0; req_rnw = '0; req_addr = '0; req_wdata = '0;
    m_rd_data = '0; m_done = 1'b0; m_nack = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stb", m_start_stb, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mwdata", m_wdata, 0);
    chk("rst_rd_err", {rd_data, 15'd0, err}, 0);
    rst = 1'b1;
    tick();

    // Round-robin with all requests held.
    for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 7'h10 + 7'(i), 16'h2000 + 16'(i));
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      wait_start();
      chk("rr_maddr", m_addr, rr_addr[g]);
      serve("rr", rr_gnt[g], 5, 16'h1000 + 16'(g), 1'b0, 16'h1000 + 16'(g), 1'b0,
            rr_addr[g], 16'h2000 + 16'(rr_addr[g] - 7'h10));
      if (g == 4) req = '0;
    end
    tick();
    chk("rr_idle", busy, 0);

    // Table of single transactions; requester inputs are scrambled after grant.
    for (int v = 0; v < 4; v++) begin
      decoy(~tbl[v].rnw);
      set_slot(tbl[v].slot, tbl[v].rnw, tbl[v].addr, tbl[v].wdata);
      req = 4'b0001 << tbl[v].slot;
      tick();
      chk("tbl_stb", m_start_stb, 1);
      chk("tbl_busy", busy, 1);
      chk("tbl_rnw", m_rnw, tbl[v].rnw);
      chk("tbl_addr", m_addr, tbl[v].addr);
      chk("tbl_wdata", m_wdata, tbl[v].wdata);
      req = '0;
      decoy(~tbl[v].rnw);
      serve("tbl", tbl[v].exp_gnt, tbl[v].lat, tbl[v].mrd, tbl[v].nack,
            tbl[v].exp_rd, tbl[v].exp_err, tbl[v].addr, tbl[v].wdata);
    end

    // Stray m_done while idle.
    m_done = 1'b1; m_nack = 1'b1; m_rd_data = 16'hDEAD;
    tick();
    m_done = 1'b0; m_nack = 1'b0;
    chk("stray_done", done, 0);
    chk("stray_busy", busy, 0);
    chk("stray_gnt", gnt, 0);

    // m_done on the timeout cycle wins (TIMEOUT=8 instance).
    set_slot(2, 1'b1, 7'h33, 16'h0000);
    t_req = 4'b0100;
    tick();
    chk("sim_stb", t_m_start_stb, 1);
    t_req = '0;
    repeat (8) tick();
    chk("sim_pre_done", t_done, 0);
    m_done = 1'b1; m_rd_data = 16'hCAFE; m_nack = 1'b0;
    tick();
    m_done = 1'b0;
    chk("sim_done", t_done, 4'b0100);
    chk("sim_err", t_err, 0);
    chk("sim_rd", t_rd_data, 16'hCAFE);
    tick();
    chk("sim_busy_clr", t_busy, 0);

    // Pure timeout: done exactly 8 cycles after WAIT entry.
    t_req = 4'b0100;
    tick();
    t_req = '0;
    tick();
    chk("to_wait_busy", t_busy, 1);
    repeat (7) tick();
    chk("to_pre_done", t_done, 0);
    tick();
    chk("to_done", t_done, 4'b0100);
    chk("to_err", t_err, 1);
    chk("to_rd", t_rd_data, 0);
    tick();
    chk("to_busy_clr", t_busy, 0);

    // Reset in the middle of WAIT.
    set_slot(2, 1'b0, 7'h22, 16'h4444);
    req = 4'b0100;
    tick();
    chk("rw_gnt", gnt, 4'b0100);
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rw_gnt0", gnt, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_done0", done, 0);
    chk("rw_maddr0", m_addr, 0);
    chk("rw_mwdata0", m_wdata, 0);
    quiet = 1;
    repeat (4) begin
      tick();
      if (done !== 4'b0000 || busy !== 1'b0) quiet = 0;
    end
    chk("rw_quiet", quiet, 1);
    set_slot(0, 1'b1, 7'h01, 16'h0101);
    set_slot(3, 1'b0, 7'h03, 16'h0303);
    req = 4'b1001;
    tick();
    chk("rw_ptr0", gnt, 4'b0001);
    req = '0;
    serve("rw_a", 4'b0001, 2, 16'h7777, 1'b0, 16'h7777, 1'b0, 7'h01, 16'h0101);
    req = 4'b1000;
    tick();
    chk("rw_req3_stb", m_start_stb, 1);
    req = '0;
    serve("rw_b", 4'b1000, 3, 16'h0033, 1'b1, 16'h0033, 1'b1, 7'h03, 16'h0303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
